pipeline_execute_memory: RTL and testbench
==========================================

// Module: pipeline_execute_memory
// PURPOSE
//  EX/MEM pipeline latch plus data-memory request tracker. Captures execute-stage results
//  under hazard-unit control, drives the dmem request from the latched instruction, holds it
//  until dhit, captures load data and reports mem_busy so the hazard unit stalls upstream.
// PARAMETERS
//  CNT_W   16   width of saturating dmem wait-cycle counter (m_wait_cnt)
// PORTS
//  CLK          in   1   clock, rising edge
//  nRST         in   1   reset, asynchronous, active-low
//  em_state     in   2   latch control from hazard unit: PIPE_ENABLE / PIPE_STALL / PIPE_NOP
//  e_dREN       in   1   execute: load instruction
//  e_dWEN       in   1   execute: store instruction
//  e_RegWrite   in   1   execute: writes register file
//  e_MemToReg   in   1   execute: writeback selects load data
//  e_halt       in   1   execute: halt instruction
//  e_alu_out    in   32  execute: ALU result / memory address
//  e_rdat2      in   32  execute: store data (forwarded rt)
//  e_wsel       in   5   execute: destination register
//  e_pc4        in   32  execute: PC+4 (JAL link)
//  dhit         in   1   dmem: request complete this cycle
//  dmemload     in   32  dmem: load data, valid when dhit
//  dmemREN      out  1   dmem read request
//  dmemWEN      out  1   dmem write request
//  dmemaddr     out  32  dmem address (= m_alu_out)
//  dmemstore    out  32  dmem store data (= m_rdat2)
//  m_RegWrite, m_MemToReg, m_halt  out 1 each  latched controls to writeback
//  m_alu_out, m_pc4, m_dload       out 32 each latched ALU result, PC+4, captured load data
//  m_wsel       out  5   latched destination register
//  mem_busy     out  1   request outstanding; hazard unit must hold em_state != PIPE_ENABLE
//  m_wait_cnt   out  CNT_W  total cycles spent in REQ since reset, saturating
// BEHAVIOUR
//  Reset (nRST=0, async): every m_* output 0, FSM IDLE, m_wait_cnt 0, dmemREN/WEN 0.
//  Latch update, at posedge, only when mem_busy=0 and m_halt=0:
//   PIPE_ENABLE: all m_* <= e_*; m_dload <= 0. PIPE_NOP: all m_* <= 0 (bubble).
//   PIPE_STALL or any other encoding: hold.
//  mem_busy=1: latch holds regardless of em_state (ENABLE/NOP ignored, not queued).
//  m_halt=1: sticky; latch frozen until reset; dmem request still completes if outstanding.
//  FSM (2 states): IDLE -> REQ on a PIPE_ENABLE load with e_dREN|e_dWEN=1.
//   REQ -> IDLE on dhit=1; m_dload <= dmemload when m_dREN. Else stay in REQ.
//  dmemREN = (state==REQ)&m_dREN; dmemWEN = (state==REQ)&m_dWEN; mem_busy = (state==REQ).
//  Latency: request visible the cycle after capture; minimum 1 REQ cycle (dhit same cycle).
//  dhit sampled only in REQ; dhit in IDLE ignored. e_dREN&e_dWEN both 1: treated as load.
//  Back-to-back: in the cycle dhit returns, latch still holds; next instruction is
//   captured on the following edge (mem_busy already 0 that cycle via state update).
//  m_wait_cnt += 1 each cycle in REQ; sticks at 2^CNT_W-1.
//  Reset mid-request: request dropped immediately, no data captured.
// TESTING
//  1 ENABLE ALU op (RegWrite=1, wsel=5, alu_out=0x10) -> next cycle m_alu_out=0x10, mem_busy=0.
//  2 ENABLE load addr 0x40, dhit after 3 cycles, dmemload=0xDEADBEEF -> dmemREN high 3 cycles,
//    m_dload=0xDEADBEEF, mem_busy 1->0, m_wait_cnt=3.
//  3 Store addr 0x80 data 0x1234, em_state=ENABLE held during REQ -> dmemWEN/addr/store stable
//    until dhit; new instruction captured only the edge after dhit.
//  4 PIPE_NOP in IDLE -> all m_* 0; PIPE_STALL -> m_* unchanged.
//  5 Halt captured, then ENABLE with new values -> m_halt=1, latch unchanged.
//  6 nRST low during REQ -> dmemREN=0, m_* 0, m_wait_cnt 0 asynchronously; dhit afterwards ignored.

Source files
------------

// File: rtl/pipeline_execute_memory_if.sv
// EX/MEM interface: execute-stage results, hazard control, dmem bus and latched writeback outputs.
// slave = the EX/MEM latch, master = the surrounding pipeline / memory side.
interface pipeline_execute_memory_if #(
   parameter int CNT_W = 16
);
   logic [1:0]       em_state;
   logic             e_dREN;
   logic             e_dWEN;
   logic             e_RegWrite;
   logic             e_MemToReg;
   logic             e_halt;
   logic [31:0]      e_alu_out;
   logic [31:0]      e_rdat2;
   logic [4:0]       e_wsel;
   logic [31:0]      e_pc4;
   logic             dhit;
   logic [31:0]      dmemload;
   logic             dmemREN;
   logic             dmemWEN;
   logic [31:0]      dmemaddr;
   logic [31:0]      dmemstore;
   logic             m_RegWrite;
   logic             m_MemToReg;
   logic             m_halt;
   logic [31:0]      m_alu_out;
   logic [31:0]      m_pc4;
   logic [31:0]      m_dload;
   logic [4:0]       m_wsel;
   logic             mem_busy;
   logic [CNT_W-1:0] m_wait_cnt;

   modport slave (
      input  em_state, e_dREN, e_dWEN, e_RegWrite, e_MemToReg, e_halt,
             e_alu_out, e_rdat2, e_wsel, e_pc4, dhit, dmemload,
      output dmemREN, dmemWEN, dmemaddr, dmemstore, m_RegWrite, m_MemToReg,
             m_halt, m_alu_out, m_pc4, m_dload, m_wsel, mem_busy, m_wait_cnt
   );

   modport master (
      output em_state, e_dREN, e_dWEN, e_RegWrite, e_MemToReg, e_halt,
             e_alu_out, e_rdat2, e_wsel, e_pc4, dhit, dmemload,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, m_RegWrite, m_MemToReg,
             m_halt, m_alu_out, m_pc4, m_dload, m_wsel, mem_busy, m_wait_cnt
   );
endinterface

// File: rtl/pipeline_execute_memory.sv
// EX/MEM latch with dmem request tracker: request issues the cycle after capture and holds until dhit;
// mem_busy stalls upstream while a request is outstanding, halt freezes the latch until reset.
module pipeline_execute_memory #(
   parameter int CNT_W = 16
) (
   input logic CLK,
   input logic nRST,
   pipeline_execute_memory_if.slave bus
);
   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_NOP    = 2'd2
   } pipe_ctrl_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   typedef struct packed {
      logic        dren;
      logic        dwen;
      logic        reg_write;
      logic        mem_to_reg;
      logic        halt;
      logic [31:0] alu_out;
      logic [31:0] rdat2;
      logic [4:0]  wsel;
      logic [31:0] pc4;
   } ex_t;

   state_t           state;
   state_t           state_nxt;
   ex_t              m_lat;
   ex_t              e_in;
   logic [31:0]      dload;
   logic [CNT_W-1:0] wait_cnt;
   logic             latch_open;
   logic             capture;
   logic             bubble;
   logic             dmem_ren;
   logic             dmem_wen;
   logic             busy;

   // A load+store encoding is issued as a load only.
   always_comb begin
      e_in            = '0;
      e_in.dren       = bus.e_dREN;
      e_in.dwen       = bus.e_dWEN & ~bus.e_dREN;
      e_in.reg_write  = bus.e_RegWrite;
      e_in.mem_to_reg = bus.e_MemToReg;
      e_in.halt       = bus.e_halt;
      e_in.alu_out    = bus.e_alu_out;
      e_in.rdat2      = bus.e_rdat2;
      e_in.wsel       = bus.e_wsel;
      e_in.pc4        = bus.e_pc4;
   end

   assign latch_open = (state == IDLE) & ~m_lat.halt;
   assign capture    = latch_open & (bus.em_state == PIPE_ENABLE);
   assign bubble     = latch_open & (bus.em_state == PIPE_NOP);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (capture && (e_in.dren || e_in.dwen)) state_nxt = REQ;
         REQ:  if (bus.dhit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
      busy     = 1'b0;
      if (state == REQ) begin
         dmem_ren = m_lat.dren;
         dmem_wen = m_lat.dwen;
         busy     = 1'b1;
      end
   end

   // Capture and load-data return never coincide: capture requires IDLE.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_lat <= '0;
         dload <= '0;
      end else if (capture) begin
         m_lat <= e_in;
         dload <= '0;
      end else if (bubble) begin
         m_lat <= '0;
         dload <= '0;
      end else if ((state == REQ) && bus.dhit && m_lat.dren) begin
         dload <= bus.dmemload;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt <= '0;
      end else if ((state == REQ) && (wait_cnt != '1)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign bus.dmemREN    = dmem_ren;
   assign bus.dmemWEN    = dmem_wen;
   assign bus.dmemaddr   = m_lat.alu_out;
   assign bus.dmemstore  = m_lat.rdat2;
   assign bus.mem_busy   = busy;
   assign bus.m_RegWrite = m_lat.reg_write;
   assign bus.m_MemToReg = m_lat.mem_to_reg;
   assign bus.m_halt     = m_lat.halt;
   assign bus.m_alu_out  = m_lat.alu_out;
   assign bus.m_pc4      = m_lat.pc4;
   assign bus.m_wsel     = m_lat.wsel;
   assign bus.m_dload    = dload;
   assign bus.m_wait_cnt = wait_cnt;
endmodule

// File: tb/tb_pipeline_execute_memory.sv
// Directed bench for the EX/MEM latch: expected latch contents queued at drive time, popped when the DUT presents them.
module tb_pipeline_execute_memory;
   localparam int CNT_W = 4;
   localparam logic [1:0] ENABLE = 2'd0;
   localparam logic [1:0] STALL  = 2'd1;
   localparam logic [1:0] NOP    = 2'd2;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        halt;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] dload;
      logic [4:0]  wsel;
   } exp_t;

   logic clk;
   logic nrst;
   int   n_pass;
   int   n_total;
   exp_t sb[$];
   exp_t last;
   int   ren_n;
   int   wen_n;

   pipeline_execute_memory_if #(.CNT_W(CNT_W)) bus ();

   pipeline_execute_memory #(.CNT_W(CNT_W)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input logic [1:0] st, input logic ren, input logic wen, input logic rw,
                        input logic m2r, input logic halt, input logic [31:0] alu,
                        input logic [31:0] rdat2, input logic [4:0] wsel, input logic [31:0] pc4);
      bus.em_state   = st;
      bus.e_dREN     = ren;
      bus.e_dWEN     = wen;
      bus.e_RegWrite = rw;
      bus.e_MemToReg = m2r;
      bus.e_halt     = halt;
      bus.e_alu_out  = alu;
      bus.e_rdat2    = rdat2;
      bus.e_wsel     = wsel;
      bus.e_pc4      = pc4;
   endtask

   function automatic exp_t mk(input logic rw, input logic m2r, input logic halt, input logic [31:0] alu,
                               input logic [31:0] pc4, input logic [31:0] dload, input logic [4:0] wsel);
      exp_t e;
      e.rw = rw; e.m2r = m2r; e.halt = halt; e.alu = alu; e.pc4 = pc4; e.dload = dload; e.wsel = wsel;
      return e;
   endfunction

   task automatic push(input exp_t e);
      sb.push_back(e);
      last = e;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_regwrite"}, bus.m_RegWrite, e.rw);
         chk({tag, "_memtoreg"}, bus.m_MemToReg, e.m2r);
         chk({tag, "_halt"},     bus.m_halt,     e.halt);
         chk({tag, "_alu_out"},  bus.m_alu_out,  e.alu);
         chk({tag, "_pc4"},      bus.m_pc4,      e.pc4);
         chk({tag, "_dload"},    bus.m_dload,    e.dload);
         chk({tag, "_wsel"},     bus.m_wsel,     e.wsel);
      end
   endtask

   // Walks an outstanding request, checking the dmem bus stays stable, and returns dhit on cycle hit_after.
   task automatic run_req(input string tag, input int hit_after, input logic [31:0] load,
                          input logic [31:0] addr, input logic [31:0] store,
                          output int ren_cnt, output int wen_cnt);
      int n;
      n = 0;
      ren_cnt = 0;
      wen_cnt = 0;
      while (bus.mem_busy === 1'b1 && n < 64) begin
         n++;
         if (bus.dmemREN === 1'b1) ren_cnt++;
         if (bus.dmemWEN === 1'b1) wen_cnt++;
         chk({tag, "_addr"}, bus.dmemaddr, addr);
         chk({tag, "_store"}, bus.dmemstore, store);
         if (n == hit_after) begin
            bus.dhit     = 1'b1;
            bus.dmemload = load;
         end
         tick();
         bus.dhit     = 1'b0;
         bus.dmemload = 32'h0BAD_0BAD;
      end
      chk({tag, "_done"}, bus.mem_busy, 1'b0);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      nrst    = 1'b0;
      bus.dhit     = 1'b0;
      bus.dmemload = 32'h0;
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick();
      tick();

      push(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      pop_check("reset");
      chk("reset_busy", bus.mem_busy, 1'b0);
      chk("reset_ren", bus.dmemREN, 1'b0);
      chk("reset_wen", bus.dmemWEN, 1'b0);
      chk("reset_wait", bus.m_wait_cnt, 4'd0);
      nrst = 1'b1;
      tick();

      // ALU op
      drive(ENABLE, 0, 0, 1, 0, 0, 32'h10, 32'h3, 5'd5, 32'h104);
      push(mk(1, 0, 0, 32'h10, 32'h104, 32'h0, 5'd5));
      tick();
      pop_check("alu");
      chk("alu_busy", bus.mem_busy, 1'b0);
      chk("alu_ren", bus.dmemREN, 1'b0);

      // dhit while idle has no effect
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      bus.dhit = 1'b1;
      bus.dmemload = 32'hFFFF_0000;
      tick();
      bus.dhit = 1'b0;
      push(last);
      pop_check("idle_dhit");
      chk("idle_dhit_busy", bus.mem_busy, 1'b0);

      // load, dhit on third REQ cycle
      drive(ENABLE, 1, 0, 1, 1, 0, 32'h40, 32'h0, 5'd8, 32'h108);
      push(mk(1, 1, 0, 32'h40, 32'h108, 32'hDEAD_BEEF, 5'd8));
      tick();
      chk("load_busy", bus.mem_busy, 1'b1);
      chk("load_dload_cleared", bus.m_dload, 32'h0);
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      run_req("load", 3, 32'hDEAD_BEEF, 32'h40, 32'h0, ren_n, wen_n);
      chk("load_ren_cycles", ren_n, 3);
      chk("load_wen_cycles", wen_n, 0);
      chk("load_wait", bus.m_wait_cnt, 4'd3);
      pop_check("load");

      // store with ENABLE held during the request
      drive(ENABLE, 0, 1, 0, 0, 0, 32'h80, 32'h1234, 5'd0, 32'h10C);
      push(mk(0, 0, 0, 32'h80, 32'h10C, 32'h0, 5'd0));
      tick();
      drive(ENABLE, 0, 0, 1, 0, 0, 32'h55, 32'h0, 5'd9, 32'h110);
      run_req("store", 2, 32'h0, 32'h80, 32'h1234, ren_n, wen_n);
      chk("store_wen_cycles", wen_n, 2);
      chk("store_ren_cycles", ren_n, 0);
      chk("store_wait", bus.m_wait_cnt, 4'd5);
      pop_check("store_hold");
      push(mk(1, 0, 0, 32'h55, 32'h110, 32'h0, 5'd9));
      tick();
      pop_check("b2b");

      // STALL holds, NOP bubbles, unused encoding holds
      drive(STALL, 1, 0, 1, 1, 1, 32'hAA, 32'hBB, 5'd31, 32'hCC);
      push(last);
      tick();
      pop_check("stall");
      chk("stall_busy", bus.mem_busy, 1'b0);
      drive(NOP, 1, 0, 1, 1, 1, 32'hAA, 32'hBB, 5'd31, 32'hCC);
      push(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      tick();
      pop_check("nop");
      chk("nop_busy", bus.mem_busy, 1'b0);
      drive(2'd3, 0, 0, 1, 0, 0, 32'hAA, 32'hBB, 5'd31, 32'hCC);
      push(last);
      tick();
      pop_check("enc3");

      // load+store together behaves as a load; single REQ cycle
      drive(ENABLE, 1, 1, 1, 1, 0, 32'h44, 32'h9, 5'd7, 32'h300);
      push(mk(1, 1, 0, 32'h44, 32'h300, 32'h1111_2222, 5'd7));
      tick();
      chk("both_ren", bus.dmemREN, 1'b1);
      chk("both_wen", bus.dmemWEN, 1'b0);
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      run_req("both", 1, 32'h1111_2222, 32'h44, 32'h9, ren_n, wen_n);
      chk("both_ren_cycles", ren_n, 1);
      chk("both_wait", bus.m_wait_cnt, 4'd6);
      pop_check("both");

      // wait counter saturates
      drive(ENABLE, 1, 0, 1, 1, 0, 32'h48, 32'h0, 5'd2, 32'h304);
      push(mk(1, 1, 0, 32'h48, 32'h304, 32'h5A5A_5A5A, 5'd2));
      tick();
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      run_req("sat", 12, 32'h5A5A_5A5A, 32'h48, 32'h0, ren_n, wen_n);
      chk("sat_ren_cycles", ren_n, 12);
      chk("sat_wait", bus.m_wait_cnt, 4'd15);
      pop_check("sat");

      // reset in the middle of a request
      drive(ENABLE, 1, 0, 1, 1, 0, 32'h4C, 32'h0, 5'd6, 32'h308);
      tick();
      drive(STALL, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      chk("rst_pre_busy", bus.mem_busy, 1'b1);
      tick();
      #2;
      nrst = 1'b0;
      #1;
      chk("rst_async_ren", bus.dmemREN, 1'b0);
      chk("rst_async_busy", bus.mem_busy, 1'b0);
      chk("rst_async_wait", bus.m_wait_cnt, 4'd0);
      push(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      pop_check("rst_async");
      tick();
      nrst = 1'b1;
      bus.dhit = 1'b1;
      bus.dmemload = 32'hCAFE_F00D;
      tick();
      bus.dhit = 1'b0;
      chk("rst_dhit_dload", bus.m_dload, 32'h0);
      chk("rst_dhit_busy", bus.mem_busy, 1'b0);
      chk("rst_dhit_wait", bus.m_wait_cnt, 4'd0);

      // halt freezes the latch
      drive(ENABLE, 0, 0, 0, 0, 1, 32'h77, 32'h0, 5'd3, 32'h200);
      push(mk(0, 0, 1, 32'h77, 32'h200, 32'h0, 5'd3));
      tick();
      pop_check("halt");
      drive(ENABLE, 1, 0, 1, 1, 0, 32'h99, 32'h1, 5'd4, 32'h204);
      push(last);
      tick();
      pop_check("halt_enable");
      chk("halt_no_req", bus.mem_busy, 1'b0);
      drive(NOP, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      push(last);
      tick();
      pop_check("halt_nop");

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
